// File: rtl/core_defs_pkg.sv
// ============================================================================
// core_defs_pkg : shared RV32 core constants and address helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package core_defs_pkg;

  localparam int unsigned       XLEN_DEFAULT     = 32;
  localparam logic [31:0]       INST_NOP         = 32'h0000_0013;
  localparam logic [31:0]       RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : power-of-two synchronous FIFO with flush; flush beats push/pop
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign w_push = push_i && !full_o && !flush_i;
  assign w_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Storage needs no reset: empty_o qualifies every read.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/if_prefetch.sv
// ============================================================================
// if_prefetch : PC, credit-limited fetch issue, squash of stale responses
// Revision 1.0
// ============================================================================
`default_nettype none

module if_prefetch
  import core_defs_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic [XLEN-1:0] req_addr_o,
  input  logic            rsp_valid_i,
  input  logic [XLEN-1:0] rsp_data_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     w_fifo_count;
  logic [CW:0]       w_credit_used;
  logic              w_fifo_full, w_fifo_empty;
  logic [2*XLEN-1:0] w_head;
  logic [XLEN-1:0]   w_jump_pc;
  logic              w_req_fire, w_rsp_keep, w_rsp_drop;

  assign w_jump_pc     = {jump_addr_i[XLEN-1:2], 2'b00};
  assign w_credit_used = {1'b0, outst_q} + {1'b0, w_fifo_count};

  // Queue space is reserved when a request issues, so pushes can never be refused.
  assign req_valid_o = !rst && !jump_en_i && !w_fifo_full &&
                       (w_credit_used < (CW+1)'(DEPTH));
  assign req_addr_o  = fetch_pc_q;

  assign w_req_fire = req_valid_o && req_ready_i;
  assign w_rsp_keep = rsp_valid_i && (discard_q == '0);
  assign w_rsp_drop = rsp_valid_i && (discard_q != '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    if (jump_en_i) begin
      // Everything still in flight belongs to the old path.
      fetch_pc_d = w_jump_pc;
      resp_pc_d  = w_jump_pc;
      outst_d    = outst_q - CW'(rsp_valid_i);
      discard_d  = outst_q - CW'(rsp_valid_i);
    end else begin
      if (w_req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (w_rsp_keep) resp_pc_d  = resp_pc_q + XLEN'(4);
      if (w_rsp_drop) discard_d  = discard_q - 1'b1;
      outst_d = outst_q + CW'(w_req_fire) - CW'(rsp_valid_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (jump_en_i),
    .push_i  (w_rsp_keep && !jump_en_i),
    .data_i  ({resp_pc_q, rsp_data_i}),
    .pop_i   (inst_valid_o && inst_ready_i && !jump_en_i),
    .data_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  assign inst_valid_o = !w_fifo_empty;
  assign inst_o       = w_fifo_empty ? XLEN'(INST_NOP) : w_head[XLEN-1:0];
  assign inst_addr_o  = w_fifo_empty ? '0 : w_head[2*XLEN-1:XLEN];

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch.sv
// ============================================================================
// tb_if_prefetch : randomized bench against a queue-level fetch/memory model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_if_prefetch;
  import core_defs_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [31:0] req_addr_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  if_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_addr_o   (req_addr_o),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_data_i   (rsp_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o)
  );

  always #5 clk = ~clk;

  // Memory requests in flight; stale ones belong to a path abandoned by a redirect.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mem_t;

  mem_t        pend[$];
  logic [31:0] mq[$];
  logic [31:0] next_fetch;
  int          cyc, lat, n_tests, n_fail, fires;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h1357_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input bit rdy, input bit irdy, input bit jmp, input logic [31:0] ja);
    req_ready_i  = rdy;
    inst_ready_i = irdy;
    jump_en_i    = jmp;
    jump_addr_i  = ja;
    rsp_valid_i  = (pend.size() > 0) && (pend[0].due <= cyc);
    rsp_data_i   = rsp_valid_i ? mem_word(pend[0].addr) : $urandom;
  endtask

  // Compare at the falling edge, then advance the model by one clock.
  task automatic step();
    bit   exp_rv, exp_iv;
    mem_t e;
    #4;
    exp_rv = !jump_en_i && (pend.size() + mq.size() < DEPTH);
    exp_iv = mq.size() > 0;
    check("req_valid", {31'b0, req_valid_o}, {31'b0, exp_rv});
    if (exp_rv) check("req_addr", req_addr_o, next_fetch);
    check("inst_valid", {31'b0, inst_valid_o}, {31'b0, exp_iv});
    check("inst_addr", inst_addr_o, exp_iv ? mq[0] : 32'h0);
    check("inst", inst_o, exp_iv ? mem_word(mq[0]) : INST_NOP);
    if (req_valid_o && req_ready_i) fires++;

    if (jump_en_i) begin
      if (rsp_valid_i) void'(pend.pop_front());
      foreach (pend[i]) pend[i].stale = 1'b1;
      mq.delete();
      next_fetch = word_align(jump_addr_i);
    end else begin
      if (exp_iv && inst_ready_i) void'(mq.pop_front());
      if (rsp_valid_i) begin
        e = pend.pop_front();
        if (!e.stale) mq.push_back(e.addr);
      end
      if (exp_rv && req_ready_i) begin
        pend.push_back('{addr: next_fetch, due: cyc + lat, stale: 1'b0});
        next_fetch = next_fetch + 32'd4;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int n, input int p_rdy, input int p_irdy, input int p_jmp);
    for (int k = 0; k < n; k++) begin
      drive($urandom_range(99) < p_rdy, $urandom_range(99) < p_irdy,
            $urandom_range(99) < p_jmp, $urandom);
      step();
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mq.delete();
    next_fetch = RST_PC;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; fires = 0; lat = 1;
    rst = 1'b1;
    jump_en_i = 1'b0; jump_addr_i = '0; req_ready_i = 1'b0;
    rsp_valid_i = 1'b0; rsp_data_i = '0; inst_ready_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", {31'b0, req_valid_o}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
    check("rst_inst", inst_o, INST_NOP);
    check("rst_inst_addr", inst_addr_o, 32'h0);
    rst = 1'b0;

    // Streaming with single-cycle memory.
    lat = 1;
    repeat (30) begin drive(1, 1, 0, 0); step(); end

    // Decode stalled: exactly DEPTH requests go out, then drain in order.
    drive(1, 0, 1, 32'h0000_0000); step();
    fires = 0;
    repeat (20) begin drive(1, 0, 0, 0); step(); end
    check("stall_accepts", fires, DEPTH);
    check("stall_req_valid", {31'b0, req_valid_o}, 32'd0);
    repeat (15) begin drive(1, 1, 0, 0); step(); end

    // Three-cycle memory, redirect to a misaligned target.
    lat = 3;
    repeat (10) begin drive(1, 1, 0, 0); step(); end
    drive(1, 1, 1, 32'h0000_0102); step();
    check("jump_aligned_addr", req_addr_o, 32'h0000_0100);
    repeat (15) begin drive(1, 1, 0, 0); step(); end

    // Redirect landing on a cycle with both a response and a pop.
    lat = 1;
    repeat (10) begin drive(1, 1, 0, 0); step(); end
    drive(1, 1, 1, 32'h0000_0400); step();
    check("flush_empty", {31'b0, inst_valid_o}, 32'd0);
    repeat (10) begin drive(1, 1, 0, 0); step(); end

    // Random handshakes and redirects across latencies.
    for (int l = 1; l <= 3; l++) begin
      lat = l;
      rand_run(150, 60, 70, 5);
    end

    // Asynchronous reset mid-stream; memory resets alongside.
    lat = 2;
    rand_run(12, 100, 100, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_req_valid", {31'b0, req_valid_o}, 32'd0);
    check("arst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
    check("arst_inst", inst_o, INST_NOP);
    check("arst_inst_addr", inst_addr_o, 32'h0);
    model_reset();
    rsp_valid_i = 1'b0;
    jump_en_i   = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    rand_run(60, 70, 70, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
